// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte producers,
// with optional bounded burst lock and frame spacing enforced by a local timer.
module serial_tx_arbiter #(
    parameter int FRAME_CYCLES = 62400,
    parameter int TIMER_WIDTH  = 16,
    parameter int MAX_BURST    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  req_i,
    input  logic [3:0]  lock_i,
    input  logic [31:0] dat_in_i,
    output logic [3:0]  ack_o,
    output logic        txe_o,
    output logic [7:0]  dat_t_o,
    output logic [1:0]  owner_o,
    output logic        busy_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state_q;
    logic [1:0]             ptr_q;
    logic [7:0]             hold_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [3:0]             ack_q;
    logic                   txe_q;
    logic [7:0]             dat_t_q;
    logic [1:0]             owner_q;
    logic                   busy_q;

    logic [7:0] req2;
    logic [3:0] rot;
    logic [1:0] off;
    logic [1:0] win;
    logic [7:0] n_d;
    logic       keep_d;

    // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
    assign req2 = {req_i, req_i};
    assign rot  = req2[ptr_q +: 4];

    always_comb begin
        off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) off = 2'(k);
        end
        win    = ptr_q + off;
        n_d    = ((win == ptr_q) ? hold_q : 8'd0) + 8'd1;
        keep_d = lock_i[win] && (n_d < 8'(MAX_BURST));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            timer_q <= '0;
            ack_q   <= '0;
            txe_q   <= 1'b0;
            dat_t_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            txe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q      <= WAIT;
                        txe_q        <= 1'b1;
                        ack_q        <= 4'b0001 << win;
                        dat_t_q      <= dat_in_i[8*win +: 8];
                        owner_q      <= win;
                        busy_q       <= 1'b1;
                        timer_q      <= TIMER_WIDTH'(FRAME_CYCLES - 1);
                        ptr_q        <= keep_d ? win : win + 2'd1;
                        hold_q       <= keep_d ? n_d : 8'd0;
                    end
                end
                WAIT: begin
                    if (timer_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign txe_o   = txe_q;
    assign dat_t_o = dat_t_q;
    assign owner_o = owner_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with a short frame; one instance with
// burst length 4 and one with locking disabled.
module tb_serial_tx_arbiter;

    localparam int FC = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, lock = '0, req1 = '0, lock1 = '0;
    logic [31:0] dat = 32'h4433A511;
    logic [3:0]  ack, ack1;
    logic        txe, txe1, busy, busy1;
    logic [7:0]  dat_t, dat_t1;
    logic [1:0]  owner, owner1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx_arbiter #(.FRAME_CYCLES(FC), .TIMER_WIDTH(16), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .dat_in_i(dat),
        .ack_o(ack), .txe_o(txe), .dat_t_o(dat_t), .owner_o(owner), .busy_o(busy));

    serial_tx_arbiter #(.FRAME_CYCLES(FC), .TIMER_WIDTH(16), .MAX_BURST(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .lock_i(lock1), .dat_in_i(dat),
        .ack_o(ack1), .txe_o(txe1), .dat_t_o(dat_t1), .owner_o(owner1), .busy_o(busy1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_txe(input bit sel, input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel ? txe1 : txe) === 1'b1) begin
                c = cyc;
                break;
            end
        end
    endtask

    task automatic expect_grant(input bit sel, input string tag, input int w,
                                input int budget, inout int last);
        int c;
        logic [7:0] eb;
        wait_txe(sel, budget, c);
        chk({tag, "_seen"}, 32'(c >= 0), 32'd1);
        if (c >= 0) begin
            eb = dat[8*w +: 8];
            chk({tag, "_ack"},   32'(sel ? ack1 : ack),     32'(4'b0001 << w));
            chk({tag, "_owner"}, 32'(sel ? owner1 : owner), 32'(w));
            chk({tag, "_dat"},   32'(sel ? dat_t1 : dat_t), 32'(eb));
            if (last >= 0) chk({tag, "_gap"}, 32'(c - last), 32'(FC + 1));
            last = c;
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int last, nb, nt;
        int bseq [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};

        // Reset state
        @(negedge clk);
        chk("rst_txe", 32'(txe), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", 32'(dat_t), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // Single request, one-cycle latency, 20 busy cycles, no repeat
        @(negedge clk); req = 4'b0010;
        last = -1;
        expect_grant(0, "single", 1, 1, last);
        req = 4'b0000;
        nb = busy ? 1 : 0; nt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (txe) nt++;
        end
        chk("single_busy_cycles", 32'(nb), 32'(FC));
        chk("single_no_retx", 32'(nt), 0);

        // Round-robin with all four held
        pulse_rst();
        req = 4'b1111; last = -1;
        for (int k = 0; k < 5; k++) expect_grant(0, "rr", k % 4, FC + 5, last);
        req = 4'b0000;

        // Burst lock on requester 0, MAX_BURST=4
        pulse_rst();
        req = 4'b0101; lock = 4'b0001; last = -1;
        for (int k = 0; k < 10; k++) expect_grant(0, "burst", bseq[k], FC + 5, last);
        req = 4'b0000; lock = 4'b0000;

        // Locking disabled: strict alternation
        pulse_rst();
        req1 = 4'b0011; lock1 = 4'b1111; last = -1;
        for (int k = 0; k < 4; k++) expect_grant(1, "nolock", k % 2, FC + 5, last);
        req1 = 4'b0000; lock1 = 4'b0000;

        // Request pulse confined to WAIT is never granted; ptr stays at 1
        pulse_rst();
        req = 4'b0001; last = -1;
        expect_grant(0, "wd_first", 0, 2, last);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        req = 4'b1000;
        repeat (5) @(negedge clk);
        req = 4'b0000;
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (txe) nt++;
        end
        chk("wd_no_grant", 32'(nt), 0);
        req = 4'b1111; last = -1;
        expect_grant(0, "wd_ptr", 1, 2, last);
        req = 4'b0000;
        repeat (FC + 2) @(negedge clk);

        // Async reset mid-WAIT at timer=7
        pulse_rst();
        req = 4'b0100; last = -1;
        expect_grant(0, "ar_first", 2, 2, last);
        req = 4'b0000;
        repeat (12) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("ar_txe", 32'(txe), 0);
        chk("ar_ack", 32'(ack), 0);
        chk("ar_dat", 32'(dat_t), 0);
        chk("ar_owner", 32'(owner), 0);
        chk("ar_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0; req = 4'b1000; last = -1;
        expect_grant(0, "ar_regrant", 3, 2, last);
        req = 4'b0000;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
